riscv_id_stage: RTL and testbench
=================================

RISCV_ID_STAGE -- requirements
Module: riscv_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk and i_rst.
REQ-002 Parameter XLEN, 32, datapath width; legal values are 32 and 64.
REQ-003 Parameter M_EXT, 0, 1 enables decode of the RV32M opcode space (OP_ALR with funct7=0000001).
REQ-004 i_clk  in  1  clock.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_valid / o_ready  in/out  1/1  upstream handshake; i_instr  in  32  instruction; i_pc  in  XLEN  instruction address.
REQ-007 i_flush  in  1  discard all held instructions.
REQ-008 o_valid / i_ready  out/in  1/1  downstream handshake; o_pc  out  XLEN  PC of the output instruction.
REQ-009 o_opcode 7, o_funct3 3, o_funct7 7, o_src1_reg_addr 5, o_src2_reg_addr 5, o_dst_reg_addr 5, all out: raw instruction fields.
REQ-010 o_imm_num  out  XLEN  sign-extended immediate; o_src1_reg_en, o_src2_reg_en, o_dst_reg_en  out  1  register-use flags.
REQ-011 o_jal, o_memory2reg, o_mem_write, o_alures2reg, o_muldiv, o_illegal  out  1  control flags.

Function
REQ-012 All decoded outputs SHALL be registered; they change only when an instruction enters the output register.
REQ-013 Opcode class and immediate SHALL follow the RV32I U/J/I/S/B/R formats; the immediate SHALL be sign-extended from bit 31 to XLEN, including U-type when XLEN=64.
REQ-014 o_dst_reg_en SHALL be 1 only for LUI, AUIPC, JAL, JALR, LOAD, ALI and ALR with rd!=0.
REQ-015 o_illegal SHALL be 1 for: unknown opcode; ALR with funct7 not 0000000/0100000 (or 0000001 when M_EXT=1); 0100000 on ALR with funct3 other than 000/101; ALI shifts with bad funct7 (bit 25 permitted only when XLEN=64).
REQ-016 When o_illegal=1, all register-enable, jal, memory, alures2reg and muldiv flags SHALL be 0 and o_imm_num SHALL be 0; the instruction still flows with o_valid=1.
REQ-017 o_muldiv SHALL be 1 only for ALR with funct7=0000001 and M_EXT=1.
REQ-018 State machine states: EMPTY (no output), FULL (output valid), SKID (output plus skid entry valid), STALL (output holds an instruction but o_valid=0).
REQ-019 o_ready SHALL be 1 in EMPTY and FULL, and 0 in SKID and STALL, during i_rst, and during i_flush.
REQ-020 EMPTY + accept -> FULL; FULL + i_ready + accept -> FULL (new instr); FULL + i_ready, no accept -> EMPTY; FULL + !i_ready + accept -> SKID.
REQ-021 SKID + i_ready -> the skid entry moves to the output register -> FULL; SKID + !i_ready -> hold.
REQ-022 Load-use: if an instruction enters the output register in the same cycle a LOAD with rd!=0 transfers out, and that instruction has an enabled source equal to that rd, the state SHALL go to STALL; STALL -> FULL after exactly one cycle.
REQ-023 Latency: accept to o_valid SHALL be 1 cycle, or 2 cycles with a load-use stall; throughput SHALL be 1 instruction per cycle when no stall occurs.
REQ-024 i_flush SHALL have priority over every other event: the next state is EMPTY, the skid entry is invalidated, and nothing is accepted in the flush cycle.
REQ-025 o_valid SHALL be 1 only in FULL and SKID; o_valid, once asserted, SHALL hold with stable outputs until i_ready or i_flush.

Reset
REQ-026 While i_rst=1, the state SHALL be EMPTY; the skid entry and load tracking SHALL be cleared; all outputs SHALL be 0, including o_ready.
REQ-027 A reset asserted mid-operation SHALL discard the held instructions, with no o_valid in the cycle after reset is released.

Verification
REQ-028 0x00500093 (addi x1,x0,5), i_ready=1 -> next cycle o_valid=1, o_imm_num=5, o_dst_reg_addr=1, o_src1_reg_en=1, o_src2_reg_en=0, o_alures2reg=1.
REQ-029 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2) back-to-back -> the add is delayed by one o_valid=0 cycle (STALL); 0x002081B3 (add x3,x1,x2) instead -> no bubble.
REQ-030 0xFFDFF0EF (jal x1,-4) -> o_jal=1, o_imm_num=0xFFFFFFFC; with XLEN=64, 0x800002B7 (lui x5,0x80000) -> o_imm_num=0xFFFFFFFF80000000.
REQ-031 0x022081B3 (mul) with M_EXT=0 -> o_illegal=1, all flags 0; with M_EXT=1 -> o_muldiv=1, o_illegal=0.
REQ-032 i_ready=0 for 3 cycles while 3 instructions are offered -> the 2nd goes to skid, o_ready=0, the 3rd is held upstream; release -> in-order output, nothing lost.
REQ-033 i_flush in SKID state -> EMPTY next cycle, o_valid=0, o_ready=1; the skid entry is never output.

Source files
------------

// File: rtl/riscv_id_stage_if.sv
// riscv_id_stage_if: upstream/downstream handshake and decoded-instruction bundle of the decode stage.
interface riscv_id_stage_if #(parameter int XLEN = 32);
    logic            i_valid, o_ready, i_flush, o_valid, i_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_pc, o_pc, o_imm_num;
    logic [6:0]      o_opcode, o_funct7;
    logic [2:0]      o_funct3;
    logic [4:0]      o_src1_reg_addr, o_src2_reg_addr, o_dst_reg_addr;
    logic            o_src1_reg_en, o_src2_reg_en, o_dst_reg_en;
    logic            o_jal, o_memory2reg, o_mem_write, o_alures2reg, o_muldiv, o_illegal;
    modport master (
        output i_valid, i_instr, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_pc, o_imm_num, o_opcode, o_funct7, o_funct3,
               o_src1_reg_addr, o_src2_reg_addr, o_dst_reg_addr,
               o_src1_reg_en, o_src2_reg_en, o_dst_reg_en,
               o_jal, o_memory2reg, o_mem_write, o_alures2reg, o_muldiv, o_illegal
    );
    modport slave (
        input  i_valid, i_instr, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_pc, o_imm_num, o_opcode, o_funct7, o_funct3,
               o_src1_reg_addr, o_src2_reg_addr, o_dst_reg_addr,
               o_src1_reg_en, o_src2_reg_en, o_dst_reg_en,
               o_jal, o_memory2reg, o_mem_write, o_alures2reg, o_muldiv, o_illegal
    );
endinterface

// File: rtl/riscv_id_stage.sv
// riscv_id_stage: registered RV32I(+M) decoder with a one-entry skid buffer and load-use stall.
module riscv_id_stage #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b0
) (
    input logic             i_clk,
    input logic             i_rst,
    riscv_id_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID, STALL} state_t;
    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm, pc;
        logic            rs1_en, rs2_en, rd_en, jal, mem2reg, mem_write, alu2reg, muldiv, illegal;
    } dec_t;
    localparam logic [6:0] SH_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    state_t          state_q, state_d;
    dec_t            out_q, dec;
    logic [31:0]     skid_instr_q, instr, imm32;
    logic [XLEN-1:0] skid_pc_q;
    logic [6:0]      op, f7, sh_f7;
    logic [2:0]      f3;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_ali, is_alr;
    logic            alr_bad, ali_bad, illegal, accept, hazard, load, skid_we;

    // The skid entry has priority as decode source so order is preserved
    assign instr    = (state_q == SKID) ? skid_instr_q : bus.i_instr;
    assign op       = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign sh_f7    = f7 & SH_MASK;
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111;
    assign is_br    = op == 7'b1100011;
    assign is_ld    = op == 7'b0000011;
    assign is_st    = op == 7'b0100011;
    assign is_ali   = op == 7'b0010011;
    assign is_alr   = op == 7'b0110011;
    assign alr_bad  = is_alr && !(f7 == 7'b0000000 || (M_EXT && f7 == 7'b0000001) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
    assign ali_bad  = is_ali && ((f3 == 3'b001 && sh_f7 != 7'd0) ||
                      (f3 == 3'b101 && sh_f7 != 7'd0 && sh_f7 != 7'b0100000));
    assign illegal  = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st || is_ali || is_alr)
                      || alr_bad || ali_bad;
    assign imm32    = (is_lui || is_auipc)         ? {instr[31:12], 12'b0} :
                      is_jal                       ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                      (is_jalr || is_ld || is_ali) ? {{20{instr[31]}}, instr[31:20]} :
                      is_st                        ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                      is_br                        ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} : 32'd0;

    always_comb begin
        dec           = '0;
        dec.opcode    = op;
        dec.funct3    = f3;
        dec.funct7    = f7;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.pc        = (state_q == SKID) ? skid_pc_q : bus.i_pc;
        dec.illegal   = illegal;
        dec.imm       = illegal ? '0 : XLEN'($signed(imm32));
        dec.rs1_en    = !illegal && (is_jalr || is_br || is_ld || is_st || is_ali || is_alr);
        dec.rs2_en    = !illegal && (is_br || is_st || is_alr);
        dec.rd_en     = !illegal && (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_ali || is_alr) && instr[11:7] != 5'd0;
        dec.jal       = !illegal && is_jal;
        dec.mem2reg   = !illegal && is_ld;
        dec.mem_write = !illegal && is_st;
        dec.alu2reg   = !illegal && (is_lui || is_auipc || is_ali || is_alr);
        dec.muldiv    = !illegal && is_alr && M_EXT && f7 == 7'b0000001;
    end

    assign bus.o_ready = !i_rst && !bus.i_flush && (state_q == EMPTY || state_q == FULL);
    assign bus.o_valid = !i_rst && (state_q == FULL || state_q == SKID);
    assign accept      = bus.i_valid && bus.o_ready;
    // A load leaving this cycle whose rd feeds the entering instruction forces one bubble
    assign hazard      = bus.o_valid && bus.i_ready && out_q.mem2reg && out_q.rd_en &&
                         ((dec.rs1_en && dec.rs1 == out_q.rd) || (dec.rs2_en && dec.rs2 == out_q.rd));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        skid_we = 1'b0;
        if (bus.i_flush) state_d = EMPTY;
        else case (state_q)
            EMPTY: begin
                state_d = accept ? FULL : EMPTY;
                load    = accept;
            end
            FULL: begin
                state_d = bus.i_ready ? (accept ? (hazard ? STALL : FULL) : EMPTY) : (accept ? SKID : FULL);
                load    = bus.i_ready && accept;
                skid_we = !bus.i_ready && accept;
            end
            SKID: begin
                state_d = bus.i_ready ? (hazard ? STALL : FULL) : SKID;
                load    = bus.i_ready;
            end
            default: state_d = FULL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= EMPTY;
            out_q        <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) out_q <= dec;
            if (skid_we) begin
                skid_instr_q <= bus.i_instr;
                skid_pc_q    <= bus.i_pc;
            end
        end
    end

    assign bus.o_pc            = out_q.pc;
    assign bus.o_imm_num       = out_q.imm;
    assign bus.o_opcode        = out_q.opcode;
    assign bus.o_funct3        = out_q.funct3;
    assign bus.o_funct7        = out_q.funct7;
    assign bus.o_src1_reg_addr = out_q.rs1;
    assign bus.o_src2_reg_addr = out_q.rs2;
    assign bus.o_dst_reg_addr  = out_q.rd;
    assign bus.o_src1_reg_en   = out_q.rs1_en;
    assign bus.o_src2_reg_en   = out_q.rs2_en;
    assign bus.o_dst_reg_en    = out_q.rd_en;
    assign bus.o_jal           = out_q.jal;
    assign bus.o_memory2reg    = out_q.mem2reg;
    assign bus.o_mem_write     = out_q.mem_write;
    assign bus.o_alures2reg    = out_q.alu2reg;
    assign bus.o_muldiv        = out_q.muldiv;
    assign bus.o_illegal       = out_q.illegal;
endmodule

// File: tb/tb_riscv_id_stage.sv
// tb_riscv_id_stage: scoreboard bench for the decode stage (RV32 default plus an RV64+M instance).
module tb_riscv_id_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [8:0]  flags;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [8:0] got_flags;

    always #5 clk = ~clk;

    riscv_id_stage_if #(.XLEN(32)) bus();
    riscv_id_stage_if #(.XLEN(64)) bus64();
    riscv_id_stage #(.XLEN(32), .M_EXT(1'b0)) dut   (.i_clk(clk), .i_rst(rst), .bus(bus));
    riscv_id_stage #(.XLEN(64), .M_EXT(1'b1)) dut64 (.i_clk(clk), .i_rst(rst), .bus(bus64));

    // {src1_en, src2_en, dst_en, jal, memory2reg, mem_write, alures2reg, muldiv, illegal}
    assign got_flags = {bus.o_src1_reg_en, bus.o_src2_reg_en, bus.o_dst_reg_en, bus.o_jal, bus.o_memory2reg,
                        bus.o_mem_write, bus.o_alures2reg, bus.o_muldiv, bus.o_illegal};

    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got pc=%h want no output", bus.o_pc);
            end else begin
                mon_e = q.pop_front();
                if (bus.o_pc !== mon_e.pc) begin bad++; $display("FAIL sb_pc got=%h want=%h", bus.o_pc, mon_e.pc); end
                total++;
                if (bus.o_imm_num !== mon_e.imm) begin bad++; $display("FAIL sb_imm pc=%h got=%h want=%h", mon_e.pc, bus.o_imm_num, mon_e.imm); end
                total++;
                if (got_flags !== mon_e.flags) begin bad++; $display("FAIL sb_flags pc=%h got=%b want=%b", mon_e.pc, got_flags, mon_e.flags); end
                total++;
                if (bus.o_dst_reg_addr !== mon_e.rd) begin bad++; $display("FAIL sb_rd pc=%h got=%0d want=%0d", mon_e.pc, bus.o_dst_reg_addr, mon_e.rd); end
            end
        end
    end

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm, input logic [8:0] fl);
        bus.i_valid = 1'b1;
        bus.i_instr = ins;
        bus.i_pc    = pc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                q.push_back('{pc, imm, fl, ins[11:7]});
                @(posedge clk); #1;
                bus.i_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL offer_timeout pc=%h got o_ready=%b want 1", pc, bus.o_ready);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b1; bus.i_instr = 32'h00500093; bus.i_pc = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.o_ready); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_valid); end
        total++; if (bus.o_imm_num !== 32'd0 || got_flags !== 9'd0) begin bad++; $display("FAIL rst_outs got imm=%h flags=%b want 0", bus.o_imm_num, got_flags); end
        total++; if (bus.o_pc !== 32'd0 || bus.o_opcode !== 7'd0) begin bad++; $display("FAIL rst_fields got pc=%h op=%h want 0", bus.o_pc, bus.o_opcode); end
        @(posedge clk); #1;
        rst = 1'b0; bus.i_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin bad++; $display("FAIL post_rst got ready=%b valid=%b want 1/0", bus.o_ready, bus.o_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        bus.i_ready = 1'b1;
        offer(32'h00500093, 32'h100, 32'd5, 9'b101000100);
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL addi_latency got valid=%b want 1", bus.o_valid); end
        total++; if (bus.o_imm_num !== 32'd5 || bus.o_dst_reg_addr !== 5'd1) begin bad++; $display("FAIL addi_fields got imm=%h rd=%0d want 5/1", bus.o_imm_num, bus.o_dst_reg_addr); end
        total++; if ({bus.o_src1_reg_en, bus.o_src2_reg_en, bus.o_alures2reg} !== 3'b101) begin bad++; $display("FAIL addi_flags got %b want 101", {bus.o_src1_reg_en, bus.o_src2_reg_en, bus.o_alures2reg}); end
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got valid=%b want 0", bus.o_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [12] = '{32'hFFDFF0EF, 32'h022081B3, 32'h0020A423, 32'hFE208CE3, 32'h800002B7, 32'hFFFFFFFF,
                                  32'h402091B3, 32'h4030D213, 32'h02009213, 32'h00000013, 32'h00001317, 32'h402081B3};
        logic [31:0] imm [12] = '{32'hFFFFFFFC, 32'h0, 32'h8, 32'hFFFFFFF8, 32'h80000000, 32'h0,
                                  32'h0, 32'h403, 32'h0, 32'h0, 32'h1000, 32'h0};
        logic [8:0]  fl  [12] = '{9'b001100000, 9'b000000001, 9'b110001000, 9'b110000000, 9'b001000100, 9'b000000001,
                                  9'b000000001, 9'b101000100, 9'b000000001, 9'b100000100, 9'b001000100, 9'b111000100};
        time t0;
        bus.i_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 12; i++) offer(ins[i], 32'h200 + 32'(4 * i), imm[i], fl[i]);
        total++; if ($time - t0 !== 120) begin bad++; $display("FAIL decode_throughput got=%0t want=120", $time - t0); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_load_use();
        bus.i_ready = 1'b1;
        offer(32'h0000A103, 32'h300, 32'd0, 9'b101010000);
        offer(32'h002101B3, 32'h304, 32'd0, 9'b111000100);
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got valid=%b ready=%b want 0/0", bus.o_valid, bus.o_ready); end
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h304) begin bad++; $display("FAIL lu_release got valid=%b pc=%h want 1/304", bus.o_valid, bus.o_pc); end
        @(posedge clk); #1;
        offer(32'h0000A103, 32'h310, 32'd0, 9'b101010000);
        offer(32'h001081B3, 32'h314, 32'd0, 9'b111000100);
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h314) begin bad++; $display("FAIL lu_nobubble got valid=%b pc=%h want 1/314", bus.o_valid, bus.o_pc); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.i_ready = 1'b0;
        fork
            begin
                offer(32'h00100293, 32'h400, 32'd1, 9'b101000100);
                offer(32'h00200313, 32'h404, 32'd2, 9'b101000100);
                offer(32'h00300393, 32'h408, 32'd3, 9'b101000100);
            end
            begin
                repeat (4) @(negedge clk);
                total++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin bad++; $display("FAIL skid_hs got ready=%b valid=%b want 0/1", bus.o_ready, bus.o_valid); end
                total++; if (bus.o_pc !== 32'h400 || bus.o_imm_num !== 32'd1) begin bad++; $display("FAIL skid_hold got pc=%h imm=%h want 400/1", bus.o_pc, bus.o_imm_num); end
                @(posedge clk); #1;
                bus.i_ready = 1'b1;
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        total++; if (q.size() !== 0) begin bad++; $display("FAIL skid_drain got pending=%0d want 0", q.size()); end
    endtask

    task automatic test_flush();
        bus.i_ready = 1'b0;
        offer(32'h00100293, 32'h500, 32'd1, 9'b101000100);
        offer(32'h00200313, 32'h504, 32'd2, 9'b101000100);
        bus.i_flush = 1'b1;
        @(negedge clk);
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want 0", bus.o_ready); end
        q.delete();
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b want 1", bus.o_ready); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid cycle=%0d got=%b want 0", i, bus.o_valid); end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.i_ready = 1'b0;
        offer(32'h00100293, 32'h600, 32'd1, 9'b101000100);
        offer(32'h00200313, 32'h604, 32'd2, 9'b101000100);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL mrst_during got valid=%b ready=%b want 0/0", bus.o_valid, bus.o_ready); end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0; bus.i_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("FAIL mrst_after got valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready); end
        total++; if (bus.o_imm_num !== 32'd0 || bus.o_pc !== 32'd0) begin bad++; $display("FAIL mrst_clear got imm=%h pc=%h want 0/0", bus.o_imm_num, bus.o_pc); end
        @(posedge clk); #1;
    endtask

    task automatic test_rv64m();
        bus64.i_ready = 1'b1;
        bus64.i_valid = 1'b1; bus64.i_instr = 32'h800002B7; bus64.i_pc = 64'h700;
        @(posedge clk); #1; bus64.i_valid = 1'b0;
        @(negedge clk);
        total++; if (bus64.o_valid !== 1'b1 || bus64.o_imm_num !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL rv64_lui got valid=%b imm=%h want 1/ffffffff80000000", bus64.o_valid, bus64.o_imm_num); end
        @(posedge clk); #1;
        bus64.i_valid = 1'b1; bus64.i_instr = 32'h022081B3; bus64.i_pc = 64'h704;
        @(posedge clk); #1; bus64.i_valid = 1'b0;
        @(negedge clk);
        total++; if ({bus64.o_muldiv, bus64.o_illegal, bus64.o_dst_reg_en} !== 3'b101) begin bad++; $display("FAIL rv64_mul got muldiv,illegal,rd_en=%b want 101", {bus64.o_muldiv, bus64.o_illegal, bus64.o_dst_reg_en}); end
        @(posedge clk); #1;
        bus64.i_valid = 1'b1; bus64.i_instr = 32'h02009213; bus64.i_pc = 64'h708;
        @(posedge clk); #1; bus64.i_valid = 1'b0;
        @(negedge clk);
        total++; if (bus64.o_illegal !== 1'b0 || bus64.o_imm_num !== 64'h20) begin bad++; $display("FAIL rv64_slli got illegal=%b imm=%h want 0/20", bus64.o_illegal, bus64.o_imm_num); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
        bus64.i_valid = 1'b0; bus64.i_instr = '0; bus64.i_pc = '0; bus64.i_flush = 1'b0; bus64.i_ready = 1'b0;
        test_reset();
        test_addi();
        test_decode();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_rv64m();
        total++; if (q.size() !== 0) begin bad++; $display("FAIL final_drain got pending=%0d want 0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
